// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        TEST   = 3'd2,
        ADDSUB = 3'd3,
        SHIFT  = 3'd4,
        HOLD   = 3'd5
    } mult_state_t;

    // mode_q value that selects two's-complement handling (sign into X, subtract on last bit)
    localparam logic MODE_SIGNED = 1'b1;

    // Bit-counter width: must be able to hold the saturated value WIDTH
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Handshake and strobe bundle between the multiplier sequencer and its datapath.
interface mult_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    import mult_pkg::*;

    localparam int CW = cnt_width(WIDTH);

    logic          Run;
    logic          ClearA_LoadB;
    logic          Signed_Mode;
    logic          M;
    logic          Clr_Ld;
    logic          ClearA;
    logic          Add;
    logic          Sub;
    logic          Shift;
    logic          Busy;
    logic          Done;
    logic [CW-1:0] Count;

    modport master (
        input  Run, ClearA_LoadB, Signed_Mode, M,
        output Clr_Ld, ClearA, Add, Sub, Shift, Busy, Done, Count
    );

    modport slave (
        output Run, ClearA_LoadB, Signed_Mode, M,
        input  Clr_Ld, ClearA, Add, Sub, Shift, Busy, Done, Count
    );

endinterface

// File: rtl/mult_bit_counter.sv
// Bit counter for the multiplier sequencer: clears at run start, counts shifts,
// saturates at WIDTH and flags the final bit.
module mult_bit_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW = cnt_width(WIDTH)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          clear,
    input  logic          inc,
    output logic          last,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != CW'(WIDTH))) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign last  = (count_q == CW'(WIDTH - 1));
    assign count = count_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Counter-driven Moore sequencer for the shift-add multiplier: one TEST/SHIFT
// pair per operand bit, an ADDSUB step when the multiplier LSB is set.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    mult_seq_ctrl_if.master bus
);

    localparam int CW = cnt_width(WIDTH);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_CLEAR  = CLEAR;
    localparam logic [2:0] ST_TEST   = TEST;
    localparam logic [2:0] ST_ADDSUB = ADDSUB;
    localparam logic [2:0] ST_SHIFT  = SHIFT;
    localparam logic [2:0] ST_HOLD   = HOLD;

    if ((WIDTH < 2) || (WIDTH > 32)) begin : g_bad_width
        $error("mult_seq_ctrl: WIDTH must be in 2..32");
    end

    logic [2:0]    state_q, state_d;
    logic          mode_q;
    logic          last;
    logic [CW-1:0] count;

    mult_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .Clk   (Clk),
        .Reset (Reset),
        .clear (state_q == ST_CLEAR),
        .inc   (state_q == ST_SHIFT),
        .last  (last),
        .count (count)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == ST_IDLE) && bus.Run) begin
                mode_q <= bus.Signed_Mode;
            end
        end
    end

    // HOLD waits for Run to drop so a held button cannot restart the run
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.Run) state_d = ST_CLEAR;
            ST_CLEAR:  state_d = ST_TEST;
            ST_TEST:   state_d = bus.M ? ST_ADDSUB : ST_SHIFT;
            ST_ADDSUB: state_d = ST_SHIFT;
            ST_SHIFT:  state_d = last ? ST_HOLD : ST_TEST;
            ST_HOLD:   if (!bus.Run) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Clr_Ld is gated by Reset because state_q already reads IDLE during reset
    always_comb begin
        bus.Clr_Ld = (state_q == ST_IDLE) && bus.ClearA_LoadB && !Reset;
        bus.ClearA = (state_q == ST_CLEAR);
        bus.Add    = (state_q == ST_ADDSUB) && !(last && (mode_q == MODE_SIGNED));
        bus.Sub    = (state_q == ST_ADDSUB) && last && (mode_q == MODE_SIGNED);
        bus.Shift  = (state_q == ST_SHIFT);
        bus.Busy   = (state_q == ST_CLEAR) || (state_q == ST_TEST) ||
                     (state_q == ST_ADDSUB) || (state_q == ST_SHIFT);
        bus.Done   = (state_q == ST_HOLD);
    end

    assign bus.Count = count;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl: WIDTH=8 and WIDTH=16 controllers, each driving
// a behavioural shift-add datapath, checked against hand-computed run records.
`timescale 1ns/100ps
module tb_mult_seq_ctrl;
    import mult_pkg::*;

    logic Clk     = 1'b0;
    logic Reset   = 1'b0;
    logic clk_run = 1'b0;
    logic probe   = 1'b0;

    always begin
        #5;
        if (clk_run) Clk = ~Clk;
    end

    logic        run_i  [2];
    logic        clb_i  [2];
    logic        sm_i   [2];
    logic        dp_sgn [2];
    logic [31:0] sw     [2];

    logic [7:0]  a8, b8;
    logic        x8;
    logic [15:0] a16, b16;
    logic        x16;

    mult_seq_ctrl_if #(.WIDTH(8))  a_if ();
    mult_seq_ctrl_if #(.WIDTH(16)) b_if ();

    assign a_if.Run          = run_i[0];
    assign a_if.ClearA_LoadB = clb_i[0];
    assign a_if.Signed_Mode  = sm_i[0];
    assign a_if.M            = b8[0];
    assign b_if.Run          = run_i[1];
    assign b_if.ClearA_LoadB = clb_i[1];
    assign b_if.Signed_Mode  = sm_i[1];
    assign b_if.M            = b16[0];

    mult_seq_ctrl #(.WIDTH(8)) u_dut8 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (a_if.master)
    );

    mult_seq_ctrl #(.WIDTH(16)) u_dut16 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (b_if.master)
    );

    // Behavioural register unit + adder, S taken from the switches
    always @(posedge Clk) begin
        if (a_if.Clr_Ld) begin
            a8 <= '0; x8 <= 1'b0; b8 <= sw[0][7:0];
        end else if (a_if.ClearA) begin
            a8 <= '0; x8 <= 1'b0;
        end else if (a_if.Add) begin
            {x8, a8} <= dp_sgn[0] ? ({a8[7], a8} + {sw[0][7], sw[0][7:0]})
                                  : ({1'b0, a8} + {1'b0, sw[0][7:0]});
        end else if (a_if.Sub) begin
            {x8, a8} <= {a8[7], a8} - {sw[0][7], sw[0][7:0]};
        end else if (a_if.Shift) begin
            {x8, a8, b8} <= {(dp_sgn[0] ? x8 : 1'b0), x8, a8, b8[7:1]};
        end
    end

    always @(posedge Clk) begin
        if (b_if.Clr_Ld) begin
            a16 <= '0; x16 <= 1'b0; b16 <= sw[1][15:0];
        end else if (b_if.ClearA) begin
            a16 <= '0; x16 <= 1'b0;
        end else if (b_if.Add) begin
            {x16, a16} <= dp_sgn[1] ? ({a16[15], a16} + {sw[1][15], sw[1][15:0]})
                                    : ({1'b0, a16} + {1'b0, sw[1][15:0]});
        end else if (b_if.Sub) begin
            {x16, a16} <= {a16[15], a16} - {sw[1][15], sw[1][15:0]};
        end else if (b_if.Shift) begin
            {x16, a16, b16} <= {(dp_sgn[1] ? x16 : 1'b0), x16, a16, b16[15:1]};
        end
    end

    // Snapshot layout: {Clr_Ld, ClearA, Add, Sub, Shift, Busy, Done, Count[7:0]}
    localparam logic [6:0] F_NONE  = 7'b0000000;
    localparam logic [6:0] F_CLRLD = 7'b1000000;
    localparam logic [6:0] F_CLEAR = 7'b0100010;
    localparam logic [6:0] F_ADD   = 7'b0010010;
    localparam logic [6:0] F_HOLD  = 7'b0000001;

    function automatic logic [14:0] snap(input int inst);
        if (inst == 0)
            return {a_if.Clr_Ld, a_if.ClearA, a_if.Add, a_if.Sub, a_if.Shift,
                    a_if.Busy, a_if.Done, 8'(a_if.Count)};
        return {b_if.Clr_Ld, b_if.ClearA, b_if.Add, b_if.Sub, b_if.Shift,
                b_if.Busy, b_if.Done, 8'(b_if.Count)};
    endfunction

    function automatic logic [14:0] mk(input logic [6:0] f, input int cnt);
        return {f, 8'(cnt)};
    endfunction

    function automatic logic [31:0] product(input int inst);
        if (inst == 0) return {16'h0, a8, b8};
        return {a16, b16};
    endfunction

    typedef struct {
        string       name;
        int          inst;
        logic [14:0] exp;
    } now_t;

    typedef struct {
        string       name;
        int          inst;
        int          adds;
        int          subs;
        int          shifts;
        int          busy;
        int          last_as;
        logic [31:0] prod;
    } run_t;

    now_t now_q[$];
    run_t run_q[$];

    int checks = 0;
    int errors = 0;

    function automatic void cmp(input string n, input int inst, input longint got,
                                input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s (inst %0d): got 0x%0h, expected 0x%0h", n, inst, got, exp);
        end
    endfunction

    int   st_adds [2];
    int   st_subs [2];
    int   st_shift[2];
    int   st_busy [2];
    int   st_last [2];
    int   st_clrld[2];
    logic prev_done[2];

    // Monitor: immediate snapshots on probe, run statistics and record checks on negedge
    always @(negedge Clk or posedge probe) begin
        if (probe) begin
            while (now_q.size() > 0) begin : b_now
                now_t n;
                n = now_q.pop_front();
                cmp(n.name, n.inst, longint'(snap(n.inst)), longint'(n.exp));
            end
        end else begin
            for (int i = 0; i < 2; i++) begin : b_inst
                logic [14:0] s;
                run_t        r;
                s = snap(i);
                if (s[13]) begin
                    st_adds[i] = 0; st_subs[i] = 0; st_shift[i] = 0;
                    st_busy[i] = 1; st_last[i] = -1; st_clrld[i] = 0;
                end else begin
                    if (s[9]) st_busy[i]++;
                    if (s[12]) st_adds[i]++;
                    if (s[11]) st_subs[i]++;
                    if (s[10]) st_shift[i]++;
                    if (s[12] || s[11]) st_last[i] = int'(s[7:0]);
                    if (s[14] && s[9]) st_clrld[i]++;
                end
                if (s[8] && !prev_done[i]) begin
                    if (run_q.size() == 0) begin
                        cmp("unexpected_done", i, 1, 0);
                    end else begin
                        r = run_q.pop_front();
                        cmp({r.name, "_inst"},   i, i,           r.inst);
                        cmp({r.name, "_adds"},   i, st_adds[i],  r.adds);
                        cmp({r.name, "_subs"},   i, st_subs[i],  r.subs);
                        cmp({r.name, "_shifts"}, i, st_shift[i], r.shifts);
                        cmp({r.name, "_busy"},   i, st_busy[i],  r.busy);
                        cmp({r.name, "_lastas"}, i, st_last[i],  r.last_as);
                        cmp({r.name, "_clrld"},  i, st_clrld[i], 0);
                        cmp({r.name, "_prod"},   i, longint'(product(i)), longint'(r.prod));
                    end
                end
                prev_done[i] = s[8];
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_now(input string n, input int inst, input logic [14:0] e);
        now_t t;
        t.name = n; t.inst = inst; t.exp = e;
        now_q.push_back(t);
        #0.5 probe = 1'b1;
        #0.5 probe = 1'b0;
    endtask

    task automatic expect_run(input string n, input int inst, input int adds, input int subs,
                              input int shifts, input int busy, input int last_as,
                              input logic [31:0] prod);
        run_t r;
        r.name = n; r.inst = inst; r.adds = adds; r.subs = subs; r.shifts = shifts;
        r.busy = busy; r.last_as = last_as; r.prod = prod;
        run_q.push_back(r);
    endtask

    task automatic wait_done(input int inst, input int w, input string n);
        for (int k = 0; (k < 200) && !((inst == 0) ? a_if.Done : b_if.Done); k++) tick();
        check_now({n, "_hold"}, inst, mk(F_HOLD, w));
    endtask

    task automatic do_run(input int inst, input int w, input logic [31:0] b,
                          input logic [31:0] s, input logic sgn, input logic toggle,
                          input string n);
        sw[inst] = b; clb_i[inst] = 1'b1;
        tick();
        clb_i[inst] = 1'b0; sw[inst] = s; sm_i[inst] = sgn; dp_sgn[inst] = sgn;
        run_i[inst] = 1'b1;
        tick();
        run_i[inst] = 1'b0;
        if (toggle) begin
            repeat (5) tick();
            sm_i[inst] = ~sgn;
        end
        wait_done(inst, w, n);
        tick();
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            run_i[i] = 1'b0; clb_i[i] = 1'b0; sm_i[i] = 1'b0; dp_sgn[i] = 1'b0;
            sw[i] = '0; prev_done[i] = 1'b0;
            st_adds[i] = 0; st_subs[i] = 0; st_shift[i] = 0;
            st_busy[i] = 0; st_last[i] = -1; st_clrld[i] = 0;
        end
        a8 = '0; b8 = '0; x8 = 1'b0; a16 = '0; b16 = '0; x16 = 1'b0;

        // Reset with the clock stopped
        #3 Reset = 1'b1;
        #2;
        check_now("rst_w8", 0, mk(F_NONE, 0));
        check_now("rst_w16", 1, mk(F_NONE, 0));
        sw[0] = 32'hFF; clb_i[0] = 1'b1;
        check_now("rst_masks_clrld", 0, mk(F_NONE, 0));
        Reset = 1'b0;
        check_now("idle_clrld", 0, mk(F_CLRLD, 0));

        // Run and ClearA_LoadB together: operand loads, Run wins; Clr_Ld stays low while Busy
        sm_i[0] = 1'b1; dp_sgn[0] = 1'b1; run_i[0] = 1'b1;
        expect_run("w8_s_ff", 0, 7, 1, 8, 25, 7, 32'hFFFD);
        clk_run = 1'b1;
        tick();
        check_now("run_wins", 0, mk(F_CLEAR, 0));
        sw[0] = 32'h03; run_i[0] = 1'b0;
        wait_done(0, 8, "w8_s_ff");
        clb_i[0] = 1'b0;
        tick();

        expect_run("w8_u_80", 0, 1, 0, 8, 18, 7, 32'h7F80);
        do_run(0, 8, 32'h80, 32'hFF, 1'b0, 1'b0, "w8_u_80");

        expect_run("w16_s_0", 1, 0, 0, 16, 33, -1, 32'h0);
        do_run(1, 16, 32'h0, 32'h1234, 1'b1, 1'b1, "w16_s_0");

        expect_run("w8_s_81", 0, 1, 1, 8, 19, 7, 32'hFF02);
        do_run(0, 8, 32'h81, 32'h02, 1'b1, 1'b1, "w8_s_81");

        // Run held through Done, then released, then pressed again
        expect_run("w8_s_05", 0, 2, 0, 8, 19, 2, 32'hFFF1);
        sw[0] = 32'h05; clb_i[0] = 1'b1;
        tick();
        clb_i[0] = 1'b0; sw[0] = 32'hFD; sm_i[0] = 1'b1; dp_sgn[0] = 1'b1; run_i[0] = 1'b1;
        tick();
        wait_done(0, 8, "w8_s_05");
        repeat (3) tick();
        check_now("w8_still_hold", 0, mk(F_HOLD, 8));
        run_i[0] = 1'b0;
        tick();
        check_now("w8_back_idle", 0, mk(F_NONE, 8));
        // B now holds the low product byte 0xF1 (-15); S is still -3
        expect_run("w8_s_f1", 0, 4, 1, 8, 22, 7, 32'h002D);
        run_i[0] = 1'b1;
        tick();
        check_now("w8_rerun_clear", 0, mk(F_CLEAR, 8));
        run_i[0] = 1'b0;
        wait_done(0, 8, "w8_s_f1");
        tick();

        // Reset during ADDSUB at Count=3
        sw[0] = 32'hFF; clb_i[0] = 1'b1;
        tick();
        clb_i[0] = 1'b0; sw[0] = 32'h03; sm_i[0] = 1'b1; dp_sgn[0] = 1'b1; run_i[0] = 1'b1;
        tick();
        run_i[0] = 1'b0;
        for (int k = 0; (k < 60) && !(a_if.Add && (a_if.Count == 4'd3)); k++) tick();
        check_now("addsub_c3", 0, mk(F_ADD, 3));
        Reset = 1'b1;
        check_now("rst_midrun", 0, mk(F_NONE, 0));
        Reset = 1'b0;
        tick();
        check_now("idle_after_rst", 0, mk(F_NONE, 0));

        expect_run("w8_after_rst", 0, 7, 1, 8, 25, 7, 32'hFFFD);
        do_run(0, 8, 32'hFF, 32'h03, 1'b1, 1'b0, "w8_after_rst");

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
